// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART port arbiter.
// Provides the channel FSM state encoding and the round-robin pick function.
package uart_arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN, ST_DONE} arb_state_t;

    // First set bit of valid at or after ptr, wrapping at n; 0 when none is set.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        logic [MAX_REQ-1:0] sh;
        int unsigned        idx;
        logic               found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            sh = valid >> idx;
            if (!found && (i < n) && sh[0]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_channel_arbiter.sv
// One arbitrated channel: round-robin grant, per-transaction timeout with a
// one-cycle drain window, and either captured (TX) or passthrough (RX) data.
module uart_channel_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1024,
    parameter bit          CAPTURE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*8-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    req_timeout,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    input  logic [BYTE_W-1:0]     ctrl_rdata,
    output logic [BYTE_W-1:0]     data_o
);

    localparam int unsigned OWN_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t         state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic [OWN_W-1:0]   pick;
    logic [OWN_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] owner_oh;
    logic               complete_c;
    logic               abandon_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        complete_c = 1'b0;
        abandon_c  = 1'b0;
        pick       = OWN_W'(rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr_q), NUM_REQ));
        next_ptr   = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
        owner_oh   = NUM_REQ'(1) << owner_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    data_d  = req_data[{pick, 3'b000} +: BYTE_W];
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (ctrl_ready) begin
                    complete_c = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A ready here answers the request sampled on the last BUSY edge.
                if (ctrl_ready) begin
                    complete_c = 1'b1;
                end else begin
                    abandon_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete_c || abandon_c) begin
            rr_ptr_d = next_ptr;
            state_d  = ST_DONE;
        end
        valid_d = (state_d == ST_BUSY);
    end

    assign req_ready   = complete_c ? owner_oh : '0;
    assign req_timeout = abandon_c  ? owner_oh : '0;
    assign ctrl_valid  = valid_q;
    assign data_o      = CAPTURE ? data_q : (complete_c ? ctrl_rdata : '0);

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares the UART controller byte ports between NUM_REQ requesters; TX and RX
// are arbitrated by independent round-robin channels with timeouts.
module uart_port_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        tx_req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] tx_req_data,
    output logic [NUM_REQ-1:0]        tx_req_ready,
    output logic [NUM_REQ-1:0]        tx_req_timeout,
    input  logic [NUM_REQ-1:0]        rx_req_valid,
    output logic [BYTE_W-1:0]         rx_req_data,
    output logic [NUM_REQ-1:0]        rx_req_ready,
    output logic [NUM_REQ-1:0]        rx_req_timeout,
    output logic [BYTE_W-1:0]         uart_in_data,
    output logic                      uart_in_valid,
    input  logic                      uart_in_ready,
    output logic                      uart_out_valid,
    input  logic [BYTE_W-1:0]         uart_out_data,
    input  logic                      uart_out_ready
);

    uart_channel_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .CAPTURE (1'b1)
    ) u_tx_arb (
        .clk         (clk),
        .rst_n       (reset),
        .req_valid   (tx_req_valid),
        .req_data    (tx_req_data),
        .req_ready   (tx_req_ready),
        .req_timeout (tx_req_timeout),
        .ctrl_valid  (uart_in_valid),
        .ctrl_ready  (uart_in_ready),
        .ctrl_rdata  ({BYTE_W{1'b0}}),
        .data_o      (uart_in_data)
    );

    uart_channel_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .CAPTURE (1'b0)
    ) u_rx_arb (
        .clk         (clk),
        .rst_n       (reset),
        .req_valid   (rx_req_valid),
        .req_data    ({(NUM_REQ*BYTE_W){1'b0}}),
        .req_ready   (rx_req_ready),
        .req_timeout (rx_req_timeout),
        .ctrl_valid  (uart_out_valid),
        .ctrl_ready  (uart_out_ready),
        .ctrl_rdata  (uart_out_data),
        .data_o      (rx_req_data)
    );

endmodule
